// File: rtl/blockram_dual_port_arbiter.sv
// blockram_dual_port_arbiter
// Round-robin arbiter that shares one true dual-port block RAM (registered
// read, one-cycle latency) between NUM_REQ requesters. Up to two requests are
// granted per cycle: the first in scan order drives port A, the second drives
// port B. A same-address pair in which either side writes is never granted
// together. Read data is routed back to the requester one cycle after its grant.
module blockram_dual_port_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int RAM_WIDTH = 16,
   parameter int RAM_DEPTH = 1024,
   localparam int AW = $clog2(RAM_DEPTH)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0]             we,
   input  logic [NUM_REQ*AW-1:0]          addr,
   input  logic [NUM_REQ*RAM_WIDTH-1:0]   wdata,
   output logic [NUM_REQ-1:0]             gnt,
   output logic [NUM_REQ-1:0]             rvalid,
   output logic [NUM_REQ*RAM_WIDTH-1:0]   rdata,
   output logic                           write_enable_A,
   output logic                           read_enable_A,
   output logic [AW-1:0]                  address_A,
   output logic [RAM_WIDTH-1:0]           data_in_A,
   input  logic [RAM_WIDTH-1:0]           data_out_A,
   output logic                           write_enable_B,
   output logic                           read_enable_B,
   output logic [AW-1:0]                  address_B,
   output logic [RAM_WIDTH-1:0]           data_in_B,
   input  logic [RAM_WIDTH-1:0]           data_out_B
);

   localparam int IW = $clog2(NUM_REQ);

   // Return tag: which requester owns the read data coming out of a port.
   typedef struct packed {
      logic          valid;
      logic [IW-1:0] idx;
   } tag_t;

   logic [IW-1:0]        ptr;
   logic [IW-1:0]        ptr_next;
   tag_t                 tag_a;
   tag_t                 tag_b;

   logic [NUM_REQ-1:0]   req_live;
   logic                 w0_valid;
   logic [IW-1:0]        w0_idx;
   logic                 w1_valid;
   logic [IW-1:0]        w1_idx;
   logic [IW:0]          scan_sum;
   logic [IW-1:0]        scan_idx;
   logic [IW:0]          last_sum;

   logic [AW-1:0]        addr_a  [NUM_REQ];
   logic [RAM_WIDTH-1:0] wdata_a [NUM_REQ];

   // Unpack the flat request buses into per-requester arrays.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_a[i]  = addr[i*AW +: AW];
      assign wdata_a[i] = wdata[i*RAM_WIDTH +: RAM_WIDTH];
   end

   // Nothing is granted while reset is held.
   assign req_live = rst ? '0 : req;

   // Round-robin scan from ptr: first requester wins port A, next compatible one wins port B.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
      w0_valid = 1'b0;
      w0_idx   = '0;
      w1_valid = 1'b0;
      w1_idx   = '0;
      scan_sum = '0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // NOTE: blocking assignments here, because later loop iterations must see the winners chosen by earlier ones.
         scan_sum = {1'b0, ptr} + (IW+1)'(k);
         if (scan_sum >= (IW+1)'(NUM_REQ)) begin
            scan_sum = scan_sum - (IW+1)'(NUM_REQ);
         end
         scan_idx = scan_sum[IW-1:0];
         if (req_live[scan_idx]) begin
            if (!w0_valid) begin
               w0_valid = 1'b1;
               w0_idx   = scan_idx;
            end else if (!w1_valid &&
                         !((addr_a[scan_idx] == addr_a[w0_idx]) &&
                           (we[scan_idx] || we[w0_idx]))) begin
               w1_valid = 1'b1;
               w1_idx   = scan_idx;
            end
         end
      end
   end

   // Next pointer sits one past the last granted requester, wrapping at NUM_REQ.
   always_comb begin
      last_sum = {1'b0, (w1_valid ? w1_idx : w0_idx)} + (IW+1)'(1);
      if (last_sum >= (IW+1)'(NUM_REQ)) begin
         last_sum = '0;
      end
      ptr_next = last_sum[IW-1:0];
   end

   // Grant vector and RAM port drive; an unused port is fully idle and zeroed.
   always_comb begin
      gnt            = '0;
      write_enable_A = 1'b0;
      read_enable_A  = 1'b0;
      address_A      = '0;
      data_in_A      = '0;
      write_enable_B = 1'b0;
      read_enable_B  = 1'b0;
      address_B      = '0;
      data_in_B      = '0;
      if (w0_valid) begin
         gnt[w0_idx]    = 1'b1;
         write_enable_A = we[w0_idx];
         read_enable_A  = ~we[w0_idx];
         address_A      = addr_a[w0_idx];
         data_in_A      = wdata_a[w0_idx];
      end
      if (w1_valid) begin
         gnt[w1_idx]    = 1'b1;
         write_enable_B = we[w1_idx];
         read_enable_B  = ~we[w1_idx];
         address_B      = addr_a[w1_idx];
         data_in_B      = wdata_a[w1_idx];
      end
   end

   // Pointer and return tags; a granted read tags its port for the next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr   <= '0;
         tag_a <= '0;
         tag_b <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
         tag_a.valid <= w0_valid & ~we[w0_idx];
         tag_a.idx   <= w0_idx;
         tag_b.valid <= w1_valid & ~we[w1_idx];
         tag_b.idx   <= w1_idx;
         if (w0_valid) begin
            ptr <= ptr_next;
         end
      end
   end

   // Steer RAM read data to the tagged requester; reset suppresses an in-flight return.
   always_comb begin
      rvalid = '0;
      rdata  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!rst && tag_a.valid && (tag_a.idx == IW'(i))) begin
            rvalid[i]                        = 1'b1;
            rdata[i*RAM_WIDTH +: RAM_WIDTH]  = data_out_A;
         end else if (!rst && tag_b.valid && (tag_b.idx == IW'(i))) begin
            rvalid[i]                        = 1'b1;
            rdata[i*RAM_WIDTH +: RAM_WIDTH]  = data_out_B;
         end
      end
   end

endmodule

// File: tb/tb_blockram_dual_port_arbiter.sv
// Testbench for blockram_dual_port_arbiter: a block RAM model on the RAM side,
// a behavioural arbiter model compared against the DUT every cycle, and
// directed scenarios with hand-computed literal expectations.
module tb_blockram_dual_port_arbiter;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int D  = 1024;
   localparam int AW = $clog2(D);

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_v;
   logic [N-1:0]      we_v;
   logic [AW-1:0]     a_arr [N];
   logic [W-1:0]      d_arr [N];
   logic [N*AW-1:0]   addr_p;
   logic [N*W-1:0]    wdata_p;
   logic [N-1:0]      gnt;
   logic [N-1:0]      rvalid;
   logic [N*W-1:0]    rdata;
   logic              write_enable_A, read_enable_A, write_enable_B, read_enable_B;
   logic [AW-1:0]     address_A, address_B;
   logic [W-1:0]      data_in_A, data_in_B;
   logic [W-1:0]      data_out_A, data_out_B;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Pack per-requester stimulus into the flat buses.
   always_comb begin
      addr_p  = '0;
      wdata_p = '0;
      for (int i = 0; i < N; i++) begin
         addr_p[i*AW +: AW] = a_arr[i];
         wdata_p[i*W +: W]  = d_arr[i];
      end
   end

   blockram_dual_port_arbiter #(.NUM_REQ(N), .RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .req(req_v), .we(we_v), .addr(addr_p), .wdata(wdata_p),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .write_enable_A(write_enable_A), .read_enable_A(read_enable_A),
      .address_A(address_A), .data_in_A(data_in_A), .data_out_A(data_out_A),
      .write_enable_B(write_enable_B), .read_enable_B(read_enable_B),
      .address_B(address_B), .data_in_B(data_in_B), .data_out_B(data_out_B)
   );

   // Block RAM: true dual port, registered read.
   logic [W-1:0] ram [D];
   initial begin
      for (int i = 0; i < D; i++) ram[i] = '0;
      data_out_A = '0;
      data_out_B = '0;
   end
   always @(posedge clk) begin
      if (write_enable_A) ram[address_A] <= data_in_A;
      if (read_enable_A)  data_out_A <= ram[address_A];
      if (write_enable_B) ram[address_B] <= data_in_B;
      if (read_enable_B)  data_out_B <= ram[address_B];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rd(input int i);
      return rdata[i*W +: W];
   endfunction

   // Behavioural model: pointer, expected memory contents and pending returns.
   int           m_ptr = 0;
   logic [W-1:0] m_mem [D];
   logic [N-1:0] m_pend = '0;
   logic [W-1:0] m_pdat [N];
   int           m_w0, m_w1;
   initial for (int i = 0; i < D; i++) m_mem[i] = '0;
   initial for (int i = 0; i < N; i++) m_pdat[i] = '0;

   // Compare process: derive this cycle's expected outputs and check them all.
   always @(negedge clk) begin
      logic [N-1:0]   e_gnt;
      logic [N-1:0]   e_rv;
      logic [N*W-1:0] e_rd;
      logic           e_weA, e_reA, e_weB, e_reB;
      logic [AW-1:0]  e_adA, e_adB;
      logic [W-1:0]   e_diA, e_diB;
      m_w0 = -1;
      m_w1 = -1;
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (req_v[c]) begin
               if (m_w0 < 0) m_w0 = c;
               else if (m_w1 < 0 && !(a_arr[c] == a_arr[m_w0] && (we_v[c] || we_v[m_w0]))) m_w1 = c;
            end
         end
      end
      e_gnt = '0;
      {e_weA, e_reA, e_adA, e_diA} = '0;
      {e_weB, e_reB, e_adB, e_diB} = '0;
      if (m_w0 >= 0) begin
         e_gnt[m_w0] = 1'b1;
         e_weA = we_v[m_w0]; e_reA = !we_v[m_w0]; e_adA = a_arr[m_w0]; e_diA = d_arr[m_w0];
      end
      if (m_w1 >= 0) begin
         e_gnt[m_w1] = 1'b1;
         e_weB = we_v[m_w1]; e_reB = !we_v[m_w1]; e_adB = a_arr[m_w1]; e_diB = d_arr[m_w1];
      end
      e_rv = rst ? '0 : m_pend;
      e_rd = '0;
      for (int i = 0; i < N; i++) if (e_rv[i]) e_rd[i*W +: W] = m_pdat[i];
      check("gnt", 64'(gnt), 64'(e_gnt));
      check("port_a_en", 64'({write_enable_A, read_enable_A}), 64'({e_weA, e_reA}));
      check("port_a_addr", 64'(address_A), 64'(e_adA));
      check("port_a_din", 64'(data_in_A), 64'(e_diA));
      check("port_b_en", 64'({write_enable_B, read_enable_B}), 64'({e_weB, e_reB}));
      check("port_b_addr", 64'(address_B), 64'(e_adB));
      check("port_b_din", 64'(data_in_B), 64'(e_diB));
      check("rvalid", 64'(rvalid), 64'(e_rv));
      check("rdata", 64'(rdata), 64'(e_rd));
   end

   // Model state advance on the clock edge, using the winners found above.
   always @(posedge clk) begin
      logic [N-1:0] nv;
      if (rst) begin
         m_ptr  = 0;
         m_pend = '0;
      end else begin
         nv = '0;
         if (m_w0 >= 0 && !we_v[m_w0]) begin nv[m_w0] = 1'b1; m_pdat[m_w0] = m_mem[a_arr[m_w0]]; end
         if (m_w1 >= 0 && !we_v[m_w1]) begin nv[m_w1] = 1'b1; m_pdat[m_w1] = m_mem[a_arr[m_w1]]; end
         if (m_w0 >= 0 && we_v[m_w0]) m_mem[a_arr[m_w0]] = d_arr[m_w0];
         if (m_w1 >= 0 && we_v[m_w1]) m_mem[a_arr[m_w1]] = d_arr[m_w1];
         m_pend = nv;
         if (m_w0 >= 0) m_ptr = (((m_w1 >= 0) ? m_w1 : m_w0) + 1) % N;
      end
   end

   task automatic put(input int i, input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
      req_v[i] = 1'b1;
      we_v[i]  = w;
      a_arr[i] = a;
      d_arr[i] = d;
   endtask

   task automatic idle();
      req_v = '0;
      we_v  = '0;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Directed scenarios with literal expectations.
   initial begin
      rst = 1'b1;
      idle();
      for (int i = 0; i < N; i++) begin a_arr[i] = '0; d_arr[i] = '0; end
      mid();
      check("reset_gnt", 64'(gnt), 64'h0);
      check("reset_rvalid", 64'(rvalid), 64'h0);
      nxt();
      nxt();
      rst = 1'b0;

      // Two writes in one cycle.
      put(0, 1'b1, 10'd1, 16'hABCD);
      put(1, 1'b1, 10'd2, 16'h1234);
      mid();
      check("wr2_gnt", 64'(gnt), 64'b0011);
      check("wr2_a", 64'({write_enable_A, address_A, data_in_A}), 64'({1'b1, 10'd1, 16'hABCD}));
      check("wr2_b", 64'({write_enable_B, address_B, data_in_B}), 64'({1'b1, 10'd2, 16'h1234}));
      nxt();

      // Read them back from requesters 2 and 3.
      idle();
      put(2, 1'b0, 10'd2, 16'h0);
      put(3, 1'b0, 10'd1, 16'h0);
      mid();
      check("rd2_gnt", 64'(gnt), 64'b1100);
      nxt();
      idle();
      mid();
      check("rd2_rvalid", 64'(rvalid), 64'b1100);
      check("rd2_rdata2", 64'(rd(2)), 64'h1234);
      check("rd2_rdata3", 64'(rd(3)), 64'hABCD);
      nxt();

      // All four continuously reading distinct addresses: {0,1},{2,3},...
      for (int i = 0; i < N; i++) put(i, 1'b0, AW'(10 + i), 16'h0);
      for (int c = 0; c < 4; c++) begin
         mid();
         check("rr_gnt", 64'(gnt), (c % 2 == 0) ? 64'b0011 : 64'b1100);
         if (c > 0) check("rr_rvalid", 64'(rvalid), (c % 2 == 0) ? 64'b1100 : 64'b0011);
         nxt();
      end
      idle();
      mid();
      check("rr_last_rvalid", 64'(rvalid), 64'b1100);
      nxt();

      // Same-address write then read, ptr = 0.
      put(0, 1'b1, 10'd5, 16'h00FF);
      put(1, 1'b0, 10'd5, 16'h0);
      mid();
      check("haz_gnt_t", 64'(gnt), 64'b0001);
      check("haz_b_idle", 64'({write_enable_B, read_enable_B, address_B}), 64'h0);
      nxt();
      req_v[0] = 1'b0;
      mid();
      check("haz_gnt_t1", 64'(gnt), 64'b0010);
      nxt();
      idle();
      mid();
      check("haz_rvalid", 64'(rvalid), 64'b0010);
      check("haz_rdata", 64'(rd(1)), 64'h00FF);
      nxt();

      // Write addr 7, then two same-address reads granted together (ptr = 3 wraps to 0).
      put(2, 1'b1, 10'd7, 16'h5A5A);
      mid();
      check("w7_gnt", 64'(gnt), 64'b0100);
      nxt();
      idle();
      put(0, 1'b0, 10'd7, 16'h0);
      put(3, 1'b0, 10'd7, 16'h0);
      mid();
      check("rr7_gnt", 64'(gnt), 64'b1001);
      nxt();
      idle();
      mid();
      check("rr7_rvalid", 64'(rvalid), 64'b1001);
      check("rr7_rdata0", 64'(rd(0)), 64'h5A5A);
      check("rr7_rdata3", 64'(rd(3)), 64'h5A5A);
      nxt();

      // ptr = 1: write 20, conflicting read 20 is skipped, later read 21 takes port B.
      put(1, 1'b1, 10'd20, 16'hBEEF);
      put(2, 1'b0, 10'd20, 16'h0);
      put(3, 1'b0, 10'd21, 16'h0);
      mid();
      check("skip_gnt", 64'(gnt), 64'b1010);
      nxt();
      idle();
      put(2, 1'b0, 10'd20, 16'h0);
      mid();
      check("skip_gnt_t1", 64'(gnt), 64'b0100);
      check("skip_rvalid", 64'(rvalid), 64'b1000);
      nxt();
      idle();
      mid();
      check("skip_rdata", 64'(rd(2)), 64'hBEEF);
      nxt();

      // Read granted, then reset in the following cycle.
      put(1, 1'b0, 10'd5, 16'h0);
      mid();
      check("prerst_gnt", 64'(gnt), 64'b0010);
      nxt();
      rst = 1'b1;
      idle();
      put(2, 1'b0, 10'd2, 16'h0);
      mid();
      check("inrst_gnt", 64'(gnt), 64'h0);
      check("inrst_rvalid", 64'(rvalid), 64'h0);
      check("inrst_en", 64'({write_enable_A, read_enable_A, write_enable_B, read_enable_B}), 64'h0);
      nxt();
      rst = 1'b0;
      put(0, 1'b0, 10'd1, 16'h0);
      put(1, 1'b0, 10'd2, 16'h0);
      put(2, 1'b0, 10'd7, 16'h0);
      mid();
      check("postrst_rvalid", 64'(rvalid), 64'h0);
      check("postrst_gnt", 64'(gnt), 64'b0011);
      nxt();
      req_v[0] = 1'b0;
      req_v[1] = 1'b0;
      mid();
      check("postrst_gnt_t1", 64'(gnt), 64'b0100);
      check("postrst_rdata0", 64'(rd(0)), 64'hABCD);
      check("postrst_rdata1", 64'(rd(1)), 64'h1234);
      nxt();
      idle();
      mid();
      check("postrst_rdata2", 64'(rd(2)), 64'h5A5A);
      nxt();

      // Write+write to one address, ptr = 3: requester 3 first, requester 0 next cycle.
      put(3, 1'b1, 10'd9, 16'h1111);
      put(0, 1'b1, 10'd9, 16'h2222);
      mid();
      check("ww_gnt", 64'(gnt), 64'b1000);
      nxt();
      req_v[3] = 1'b0;
      mid();
      check("ww_gnt_t1", 64'(gnt), 64'b0001);
      nxt();
      idle();
      put(1, 1'b0, 10'd9, 16'h0);
      mid();
      check("ww_rd_gnt", 64'(gnt), 64'b0010);
      nxt();
      idle();
      mid();
      check("ww_rdata", 64'(rd(1)), 64'h2222);
      nxt();

      nxt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/blockram_dual_port_arbiter.md
# blockram_dual_port_arbiter

Shares one true dual port block RAM (ports A and B, 1-cycle registered read) between NUM_REQ requesters. Each cycle it grants up to two requests in round-robin order, steers the first grant to port A and the second to port B, and blocks same-address write hazards. It routes read data back to the originating requester with a fixed latency. It sits between the client engines and the RAM and drives every RAM port signal.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- RAM_WIDTH, 16, data width
- RAM_DEPTH, 1024, words; AW = $clog2(RAM_DEPTH)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  request per requester; held until granted
- we  in  NUM_REQ  1 = write, 0 = read (valid with req)
- addr  in  NUM_REQ*AW  requester i at [i*AW +: AW]
- wdata  in  NUM_REQ*RAM_WIDTH  requester i at [i*RAM_WIDTH +: RAM_WIDTH]
- gnt  out  NUM_REQ  combinational; request accepted this cycle
- rvalid  out  NUM_REQ  read data valid for requester i
- rdata  out  NUM_REQ*RAM_WIDTH  read data, slice i meaningful when rvalid[i]
- write_enable_A / read_enable_A  out  1  RAM port A enables
- address_A  out  AW; data_in_A  out  RAM_WIDTH; data_out_A  in  RAM_WIDTH
- write_enable_B / read_enable_B / address_B / data_in_B / data_out_B  same for port B

## Operation
- State: round-robin pointer ptr (range 0..NUM_REQ-1); per-port return tags tagA/tagB (valid bit plus requester index).
- Grant scan, combinational, in order ptr, ptr+1, ... mod NUM_REQ:
  - First requester with req=1 becomes winner W0 on port A.
  - Continue scanning for W1 on port B. Skip any candidate whose addr equals W0's addr when either W0 or the candidate has we=1.
  - Skipped candidates stay pending.
- Two reads to the same address may both be granted.
- gnt[W0] and gnt[W1] = 1; all others 0.
- RAM drive:
  - Port X gets write_enable_X = we[Wx] and read_enable_X = ~we[Wx], with address and data from Wx.
  - An unused port has both enables 0 and address/data 0.
- Pointer update: if any grant, ptr <= (last granted index + 1) mod NUM_REQ; else unchanged.
- Read return:
  - A granted read sets tagX valid with index Wx.
  - Next cycle, rvalid[tag] = 1 and rdata slice = data_out_X.
  - Writes set no tag.
- A requester granted on both... impossible; each index is granted at most once per cycle.
- While rst=1: gnt = 0, all RAM enables = 0, no new grants.

## Timing
- Grant in cycle T (combinational from req). RAM samples on edge ending T. rvalid/rdata in cycle T+1, for exactly one cycle.
- Throughput: up to 2 accesses per cycle; a requester may re-request in T+1 and be granted back-to-back.
- Reset values, applied on the edge with rst=1: ptr = 0, tagA/tagB invalid, rvalid = 0, rdata = 0.
- Reset mid-operation: a read granted in the cycle before reset is discarded (its rvalid is suppressed); there is no partial state.
- Write-then-read to the same address in consecutive cycles returns the new data.
- Same-cycle same-address write+read or write+write: only the earlier requester in scan order proceeds; the other is granted at the earliest next cycle.
- Wrap-around: the pointer wraps NUM_REQ-1 → 0. No requester waits more than ceil(NUM_REQ/2) grant cycles while continuously requesting, conflicts excepted.
- Address is used modulo RAM_DEPTH; no range check.

## Test plan
- Reset, then req[0] write addr 1 = 16'hABCD, req[1] write addr 2 = 16'h1234 in the same cycle → gnt = 4'b0011, port A writes addr 1, port B writes addr 2, ptr = 2.
- Next cycle req[2] read addr 2 and req[3] read addr 1 → gnt = 4'b1100; one cycle later rvalid = 4'b1100, rdata[2] = 16'h1234, rdata[3] = 16'hABCD.
- All four requesters read distinct addresses continuously from ptr = 0 → grants {0,1}, {2,3}, {0,1}…; every requester is served every 2 cycles.
- req[0] write addr 5 = 16'h00FF and req[1] read addr 5 in the same cycle, ptr = 0 → cycle T gnt = 4'b0001; T+1 gnt = 4'b0010; T+2 rvalid[1] = 1, rdata[1] = 16'h00FF.
- Two reads of addr 7 in the same cycle → both granted; both rvalid in the next cycle with identical data.
- Grant a read in cycle T, assert rst in T+1 → rvalid stays 0, ptr = 0, no RAM enables during reset; normal operation resumes after rst deasserts.
